// File: rtl/ones_gen_pkg.sv
// Shared types and default sizing for the serial ones-stream generator.
package ones_gen_pkg;

    localparam int ONES_CNT_W     = 4;
    localparam int ONES_FRAME_LEN = 15;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EMIT_ONES  = 2'd1,
        EMIT_ZEROS = 2'd2
    } gen_state_t;

endpackage

// File: rtl/ones_gen_pend_buf.sv
// One-entry holding register. It queues the next frame's count while a frame is
// being emitted. A pop and a push in the same cycle leave the new value held
// and keep the buffer full.
module ones_gen_pend_buf #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    assign push_ready = !full_q;
    assign pop_data   = data_q;
    assign full       = full_q;

    // Next-state: a pop empties the entry, and a push (applied after it) refills it.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop) begin
            full_d = 1'b0;
        end
        if (push_valid && push_ready) begin
            full_d = 1'b1;
            data_d = push_data;
        end
    end

    // Entry storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/ones_stream_gen.sv
// Serial ones-stream generator. Each accepted count produces one FRAME_LEN-bit
// frame: count leading 1s, then 0s. The FSM state names the bit being produced
// this cycle. The output registers present that bit one cycle later, so every
// registered output (including busy) is aligned with the data it describes.
module ones_stream_gen
    import ones_gen_pkg::*;
#(
    parameter int CNT_W     = ONES_CNT_W,
    parameter int FRAME_LEN = ONES_FRAME_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [CNT_W-1:0] load_count,
    output logic             data,
    output logic             data_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy,
    output logic [CNT_W-1:0] ones_tally
);

    localparam int            PW       = $clog2(FRAME_LEN + 1);
    localparam logic [PW-1:0] LAST_POS = PW'(FRAME_LEN - 1);

    // A frame must be able to hold the largest requested count.
    generate
        if (FRAME_LEN < 1 || FRAME_LEN < (2 ** CNT_W) - 1) begin : g_bad_frame_len
            $error("ones_stream_gen: FRAME_LEN must be >= 1 and >= 2**CNT_W-1");
        end
    endgenerate

    gen_state_t       state_q, state_d;
    logic [PW-1:0]    ones_rem_q, ones_rem_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic             data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] tally_q, tally_d;

    logic             pend_full;
    logic             pend_push_valid;
    logic             pend_push_ready;
    logic             pend_pop;
    logic [CNT_W-1:0] pend_count;

    logic             accept;
    logic             frame_done;
    logic             slot_free;
    logic             bypass;
    logic             take_pend;
    logic             launch;
    logic [CNT_W-1:0] next_count;

    assign load_ready = pend_push_ready;
    assign accept     = load_valid && load_ready;

    // The active registers can take a new count when idle or on a frame's last bit.
    // A new count goes straight to them only if nothing is already queued.
    // Otherwise it is parked in the pending entry.
    assign frame_done      = (state_q != IDLE) && (pos_q == LAST_POS);
    assign slot_free       = (state_q == IDLE) || frame_done;
    assign bypass          = slot_free && !pend_full && accept;
    assign take_pend       = frame_done && pend_full;
    assign launch          = bypass || take_pend;
    assign next_count      = take_pend ? pend_count : load_count;
    assign pend_push_valid = accept && !bypass;
    assign pend_pop        = take_pend;

    ones_gen_pend_buf #(
        .W(CNT_W)
    ) u_pend (
        .clk       (clk),
        .rst       (rst),
        .push_valid(pend_push_valid),
        .push_ready(pend_push_ready),
        .push_data (load_count),
        .pop       (pend_pop),
        .pop_data  (pend_count),
        .full      (pend_full)
    );

    // FSM and counter next-state. A launch overrides the step and starts the next
    // frame at bit 0, which gives gap-free back-to-back frames.
    always_comb begin
        state_d    = state_q;
        ones_rem_d = ones_rem_q;
        pos_d      = pos_q;
        unique case (state_q)
            EMIT_ONES: begin
                ones_rem_d = ones_rem_q - PW'(1);
                pos_d      = pos_q + PW'(1);
                if (ones_rem_q == PW'(1)) begin
                    state_d = EMIT_ZEROS;
                end
                if (pos_q == LAST_POS) begin
                    state_d = IDLE;
                end
            end
            EMIT_ZEROS: begin
                pos_d = pos_q + PW'(1);
                if (pos_q == LAST_POS) begin
                    state_d = IDLE;
                end
            end
            default: begin
            end
        endcase
        if (launch) begin
            ones_rem_d = PW'(next_count);
            pos_d      = '0;
            state_d    = (next_count != '0) ? EMIT_ONES : EMIT_ZEROS;
        end
    end

    // Output decodes of the bit being produced this cycle, registered next edge.
    always_comb begin
        data_d        = (state_q == EMIT_ONES);
        data_valid_d  = (state_q != IDLE);
        frame_start_d = (state_q != IDLE) && (pos_q == '0);
        frame_end_d   = (state_q != IDLE) && (pos_q == LAST_POS);
        busy_d        = (state_q != IDLE) || pend_full;
        tally_d       = tally_q;
        if (state_q == EMIT_ONES) begin
            tally_d = tally_q + CNT_W'(1);
        end
    end

    // State, counters and registered outputs. Reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ones_rem_q    <= '0;
            pos_q         <= '0;
            data_q        <= 1'b0;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            busy_q        <= 1'b0;
            tally_q       <= '0;
        end else begin
            state_q       <= state_d;
            ones_rem_q    <= ones_rem_d;
            pos_q         <= pos_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            busy_q        <= busy_d;
            tally_q       <= tally_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = busy_q;
    assign ones_tally  = tally_q;

endmodule
